// File: rtl/qsys_debounced_pio.sv
// -----------------------------------------------------------------------------
// qsys_debounced_pio
//
// Avalon-MM parallel input port for mechanical switches. Each input bit is
// brought into the clk domain by a two-flop synchroniser and then (optionally)
// debounced: a change is only accepted once the synchronised level has been
// stable for DEBOUNCE_CYCLES consecutive clocks. Accepted transitions of the
// selected polarity are latched in an edge-capture register that can raise a
// level interrupt through a per-bit mask.
//
// Build option:
//   QSYS_PIO_DEBOUNCE_EN  defined   -> per-bit debounce counters are built.
//                         undefined -> the debounced value is the synchronised
//                                      value itself; DEBOUNCE_CYCLES is unused.
//
// Parameters:
//   WIDTH            number of input bits (1..32)
//   DEBOUNCE_CYCLES  stable clocks needed to accept a change (2..65535)
//   EDGE_TYPE        0 = capture rising, 1 = capture falling, 2 = capture both
//
// Ports:
//   clk         clock, all state on its rising edge
//   reset       asynchronous active-high reset
//   address     register select: 0 stable, 1 irqmask, 2 edgecapture, 3 raw
//   chipselect  slave select (only qualifies writes)
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     asynchronous switch inputs
//   readdata    registered read data (latency 1), zero-extended
//   irq         level interrupt = |(edgecapture & irqmask)
// -----------------------------------------------------------------------------
module qsys_debounced_pio #(
    parameter int WIDTH           = 18,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // -------------------------------------------------------------------------
    // Register addresses
    // -------------------------------------------------------------------------
    localparam logic [1:0] ADDR_STABLE  = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] ADDR_RAW     = 2'd3;

    // -------------------------------------------------------------------------
    // Signals
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_w;      // debounced level, one bit per input
    logic [WIDTH-1:0] stable_dly_q;  // previous debounced level for edge detect
    logic [WIDTH-1:0] edge_set;      // selected-polarity transitions this cycle
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [WIDTH-1:0] edge_clr;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             wr_en;

    // Upper write-data bits beyond WIDTH are deliberately ignored.
    logic             unused_wdata;
    assign unused_wdata = ^writedata;

    // -------------------------------------------------------------------------
    // Two-flop synchroniser
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce
    // -------------------------------------------------------------------------
`ifdef QSYS_PIO_DEBOUNCE_EN
    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
            logic [15:0] cnt_q;
            logic [15:0] cnt_d;
            logic        stable_q;
            logic        stable_d;

            // The counter only runs while the synchronised level disagrees
            // with the accepted level; any return to agreement restarts it,
            // so a glitch shorter than DEBOUNCE_CYCLES never gets through.
            always_comb begin
                cnt_d    = cnt_q;
                stable_d = stable_q;
                if (sync2_q[gi] == stable_q) begin
                    cnt_d = '0;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    stable_d = sync2_q[gi];
                    cnt_d    = '0;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign stable_w[gi] = stable_q;
        end
    endgenerate
`else
    // Without debounce the synchronised level is taken as-is.
    logic [15:0] unused_debounce;
    assign unused_debounce = 16'(DEBOUNCE_CYCLES);
    assign stable_w        = sync2_q;
`endif

    // -------------------------------------------------------------------------
    // Edge detection on the debounced level
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
            if (EDGE_TYPE == 0) begin : g_rise
                assign edge_set[gi] = stable_w[gi] & ~stable_dly_q[gi];
            end else if (EDGE_TYPE == 1) begin : g_fall
                assign edge_set[gi] = ~stable_w[gi] & stable_dly_q[gi];
            end else begin : g_any
                assign edge_set[gi] = stable_w[gi] ^ stable_dly_q[gi];
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Register file next-state
    // -------------------------------------------------------------------------
    assign wr_en = chipselect & ~write_n;

    always_comb begin
        irqmask_d = irqmask_q;
        edge_clr  = '0;
        if (wr_en && (address == ADDR_IRQMASK)) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_EDGECAP)) begin
            edge_clr = writedata[WIDTH-1:0];
        end
        // Set is applied after clear so a new edge is never lost to a
        // concurrent write-1-to-clear.
        edgecap_d = (edgecap_q & ~edge_clr) | edge_set;
    end

    // Reads need no chipselect; the addressed register is captured every cycle.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_STABLE:  readdata_d[WIDTH-1:0] = stable_w;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            ADDR_RAW:     readdata_d[WIDTH-1:0] = sync2_q;
            default:      readdata_d            = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_dly_q <= '0;
            irqmask_q    <= '0;
            edgecap_q    <= '0;
            readdata_q   <= '0;
        end else begin
            stable_dly_q <= stable_w;
            irqmask_q    <= irqmask_d;
            edgecap_q    <= edgecap_d;
            readdata_q   <= readdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_qsys_debounced_pio.sv
// -----------------------------------------------------------------------------
// tb_qsys_debounced_pio
//
// Directed bench for qsys_debounced_pio (WIDTH=18, DEBOUNCE_CYCLES=4,
// EDGE_TYPE=0). Inputs are driven and outputs sampled 1 ns after each rising
// clock edge. LAT is the number of clock edges from an in_port change until
// the debounced register takes the new value (2 synchroniser + 4 debounce,
// or 2 without debounce); readdata shows it one edge later.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_qsys_debounced_pio;

`ifdef QSYS_PIO_DEBOUNCE_EN
    localparam int          LAT = 6;
    localparam logic [31:0] PAT = 32'h0000_0005;
`else
    localparam int          LAT = 2;
    localparam logic [31:0] PAT = 32'h0003_FFFF;
`endif
    localparam logic [31:0] PAT_NO0 = PAT & 32'hFFFF_FFFE;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [17:0] in_port;
    logic [31:0] readdata;
    logic        irq;

    int total;
    int passed;
    int failed;
    logic [31:0] rv;

    qsys_debounced_pio #(
        .WIDTH          (18),
        .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE      (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
            $display("check %-20s observed 0x%08h expected 0x%08h ok", tag, obs, exp);
        end else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        address = a;
        tick(1);
        v = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        total = 0; passed = 0; failed = 0;
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;

        // Reset state
        tick(2);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        tick(1);
        rd(2'd0, rv); check("rst_addr0", rv, 32'h0);
        rd(2'd1, rv); check("rst_addr1", rv, 32'h0);
        rd(2'd2, rv); check("rst_addr2", rv, 32'h0);
        rd(2'd3, rv); check("rst_addr3", rv, 32'h0);
        check("rst_irq_after", {31'b0, irq}, 32'h0);

        // Input change: stable takes it on edge LAT, readdata one edge later
        address = 2'd0;
        in_port = 18'(PAT);
        tick(LAT);
        check("stable_not_yet", readdata, 32'h0);
        tick(1);
        check("stable_latency", readdata, PAT);
        rd(2'd3, rv); check("raw_sync2", rv, PAT);
        rd(2'd2, rv); check("edgecap_first", rv, PAT);

`ifdef QSYS_PIO_DEBOUNCE_EN
        // 3-clock glitch on bit 3 is rejected
        address = 2'd0;
        in_port = 18'(PAT | 32'h8);
        tick(3);
        in_port = 18'(PAT);
        tick(10);
        check("glitch3_stable", readdata, PAT);
        rd(2'd2, rv); check("glitch3_edgecap", rv, PAT);
        // 4-clock pulse on bit 3 is accepted
        address = 2'd0;
        in_port = 18'(PAT | 32'h8);
        tick(4);
        in_port = 18'(PAT);
        tick(3);
        check("pulse4_stable", readdata, PAT | 32'h8);
        tick(10);
        check("pulse4_release", readdata, PAT);
        rd(2'd2, rv); check("pulse4_edgecap", rv, PAT | 32'h8);
        wr(2'd2, 32'h8);
        rd(2'd2, rv); check("clear_bit3", rv, PAT);
`endif

        // Writes to read-only registers and unselected writes are ignored
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd0, rv); check("ro_addr0", rv, PAT);
        rd(2'd3, rv); check("ro_addr3", rv, PAT);
        address = 2'd1; writedata = 32'h0000_0001; write_n = 1'b0; chipselect = 1'b0;
        tick(1);
        write_n = 1'b1;
        rd(2'd1, rv); check("no_cs_write", rv, 32'h0);

        // Mask and interrupt, write-1-to-clear
        wr(2'd1, 32'h0000_0001);
        check("irq_on", {31'b0, irq}, 32'h1);
        rd(2'd1, rv); check("irqmask_rb", rv, 32'h1);
        wr(2'd2, 32'h0000_0001);
        check("irq_off", {31'b0, irq}, 32'h0);
        rd(2'd2, rv); check("w1c_bit0", rv, PAT_NO0);

        // Falling edge not captured, then new rising edge coinciding with clear
        in_port = 18'(PAT_NO0);
        tick(LAT + 6);
        rd(2'd2, rv); check("fall_ignored", rv, PAT_NO0);
        in_port = 18'(PAT);
        tick(LAT);
        wr(2'd2, 32'h0000_0001);
        rd(2'd2, rv); check("set_wins", rv, PAT);
        check("set_wins_irq", {31'b0, irq}, 32'h1);

        // Mask truncated to WIDTH bits
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, rv); check("mask_trunc", rv, 32'h0003_FFFF);

        // Reset mid-debounce, then re-debounce from zero with a rising edge
        in_port = '0;
        tick(3);
        reset = 1'b1;
        #1;
        check("async_rst_rd", readdata, 32'h0);
        check("async_rst_irq", {31'b0, irq}, 32'h0);
        in_port = 18'(PAT);
        tick(2);
        reset = 1'b0;
        address = 2'd0;
        tick(LAT);
        check("rerun_not_yet", readdata, 32'h0);
        tick(1);
        check("rerun_stable", readdata, PAT);
        rd(2'd2, rv); check("rerun_edgecap", rv, PAT);
        rd(2'd1, rv); check("rerun_mask_clr", rv, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
